// File: rtl/clken_nco_pkg.sv
// Shared helpers and reference increments for the clock-enable NCO bank.
package clken_nco_pkg;

    // Address width for a bank of n channels; a single channel still gets one address bit.
    function automatic int ch_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Standard PC-XT increments for a 32-bit accumulator.
    // Index 0 is for a 50 MHz refclk, index 1 for a 100 MHz refclk.
    // inc = round(f_out / f_refclk * 2^32)
    localparam logic [31:0] INC_14M318 [2] = '{32'd1229922297, 32'd614961148};
    localparam logic [31:0] INC_4M77   [2] = '{32'd409974099,  32'd204987049};
    localparam logic [31:0] INC_3M579  [2] = '{32'd307480574,  32'd153740287};
    localparam logic [31:0] INC_1M193  [2] = '{32'd102493525,  32'd51246762};

endpackage

// File: rtl/clken_nco_ch.sv
// One NCO channel: phase accumulator, active and pending increments, and the
// wrap-aligned apply logic that keeps the output phase continuous.
module clken_nco_ch
    import clken_nco_pkg::*;
#(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             we,
    input  logic [ACC_W-1:0] data,
    output logic             ce,
    output logic             phase_msb,
    output logic             pending
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] pend_inc;
    logic [ACC_W:0]   sum;
    logic             apply;

    // One extra bit holds the carry that marks a wrap of the accumulator.
    assign sum = {1'b0, acc} + {1'b0, inc};

    // Swap increments only on a wrap, or at once when the channel is stopped.
    // A write in the same cycle takes priority and keeps the update pending.
    assign apply = pending && !we && (sum[ACC_W] || (inc == '0));

    // Accumulate every cycle; register carry and MSB as the channel outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            inc       <= INC_RST;
            pend_inc  <= '0;
            pending   <= 1'b0;
            ce        <= 1'b0;
            phase_msb <= 1'b0;
        end else begin
            acc       <= sum[ACC_W-1:0];
            ce        <= sum[ACC_W];
            phase_msb <= sum[ACC_W-1];
            if (we) begin
                pend_inc <= data;
                pending  <= 1'b1;
            end else if (apply) begin
                inc     <= pend_inc;
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clken_nco_bank.sv
// Bank of NUM_CH NCO clock-enable generators with a shared config port and a
// locked flag that reports when no increment update is in flight.
module clken_nco_bank
    import clken_nco_pkg::*;
#(
    parameter int                      NUM_CH      = 6,
    parameter int                      ACC_W       = 32,
    parameter int                      LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INC_INIT    = '0
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [ch_aw(NUM_CH)-1:0]  cfg_addr,
    input  logic [ACC_W-1:0]          cfg_data,
    output logic [NUM_CH-1:0]         ce,
    output logic [NUM_CH-1:0]         phase_msb,
    output logic [NUM_CH-1:0]         pending,
    output logic                      locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic              wr_ok;
    logic [NUM_CH-1:0] ch_we;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    // Writes to addresses beyond the last channel are dropped entirely.
    assign wr_ok = cfg_we && (32'(cfg_addr) < 32'(NUM_CH));

    // One-hot write strobe to the addressed channel.
    always_comb begin
        ch_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_ok && (32'(cfg_addr) == i)) begin
                ch_we[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clken_nco_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (INC_INIT[g*ACC_W +: ACC_W])
        ) u_ch (
            .refclk    (refclk),
            .rst       (rst),
            .we        (ch_we[g]),
            .data      (cfg_data),
            .ce        (ce[g]),
            .phase_msb (phase_msb[g]),
            .pending   (pending[g])
        );
    end

    // Quiet-time counter: cleared by any accepted write or outstanding update,
    // otherwise counts up and holds at LOCK_CYCLES.
    always_comb begin
        if (wr_ok || (|pending)) begin
            cnt_next = '0;
        end else if (cnt == CNT_W'(LOCK_CYCLES)) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    // locked tracks the counter register so it drops on the edge that accepts a write.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            locked <= (cnt_next == CNT_W'(LOCK_CYCLES));
        end
    end

endmodule
